// File: rtl/pipeline_egress_buffer.sv
// pipeline_egress_buffer: captures results from a fixed-latency pipeline tail
// into a FWFT FIFO, throttles upstream issue with credits, flags protocol errors.
module pipeline_egress_buffer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err,
    output logic                       orphan_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > 256 || LATENCY < 1) begin : g_bad_params
        $error("pipeline_egress_buffer: illegal DEPTH/LATENCY");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reserved_q, reserved_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic          ovf_q, ovf_d;
    logic          orph_q, orph_d;

    logic issue;
    logic pop;
    logic wr_en;
    logic retire;

    assign issue_ready  = (reserved_q < FULL);
    assign out_valid    = (count_q != '0);
    assign out_data     = mem[rd_ptr_q];
    assign count        = count_q;
    assign overflow_err = ovf_q;
    assign orphan_err   = orph_q;

    always_comb begin
        issue       = issue_valid && issue_ready;
        pop         = out_valid && out_ready;
        wr_en       = in_valid && ((count_q != FULL) || pop);
        retire      = in_valid && (in_flight_q != '0);
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        reserved_d  = reserved_q;
        in_flight_d = in_flight_q;
        ovf_d       = ovf_q | (in_valid && !wr_en);
        orph_d      = orph_q | (in_valid && (in_flight_q == '0));

        if (pop)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        if (wr_en)
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);

        if (wr_en && !pop)
            count_d = count_q + ONE;
        else if (!wr_en && pop)
            count_d = count_q - ONE;

        // Orphan writes can leave reserved below count; never wrap below zero.
        if (issue && !pop)
            reserved_d = reserved_q + ONE;
        else if (!issue && pop && (reserved_q != '0))
            reserved_d = reserved_q - ONE;

        if (issue && !retire)
            in_flight_d = in_flight_q + ONE;
        else if (!issue && retire)
            in_flight_d = in_flight_q - ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            reserved_q  <= '0;
            in_flight_q <= '0;
            ovf_q       <= 1'b0;
            orph_q      <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            reserved_q  <= reserved_d;
            in_flight_q <= in_flight_d;
            ovf_q       <= ovf_d;
            orph_q      <= orph_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= in_data;
    end
endmodule
